// File: rtl/alu_seq.sv
// alu_seq: multi-cycle 8x8 multiply / 8/8 divide sequencer that borrows the shared 8-bit ALU.
// Optional macro ALU_SEQ_DIV_EN adds the restoring-divide path and the div_by_zero flag.
module alu_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       op,
   input  logic [7:0] opa,
   input  logic [7:0] opb,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_mode,
   output logic       alu_cin,
   input  logic [7:0] alu_out,
   input  logic       alu_cout,
   output logic       alu_own,
   output logic       busy,
   output logic       done,
   output logic [7:0] result_hi,
   output logic [7:0] result_lo,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0] MODE_PASS = 4'b0000;
   localparam logic [3:0] MODE_ADD  = 4'b0101;

   state_t     state, state_nxt;
   logic [7:0] p, q, b;
   logic [2:0] cnt;
   logic       accept, zero_div;

`ifdef ALU_SEQ_DIV_EN
   localparam logic [3:0] MODE_SUB = 4'b1000;
   logic op_div, dz, div_ok;

   // A set P[7] means the shifted remainder exceeds any 8-bit divisor, so the subtract must succeed.
   assign div_ok      = p[7] | ~alu_cout;
   assign zero_div    = op && (opb == 8'd0);
   assign div_by_zero = dz;
`else
   logic unused_op;

   assign unused_op   = op;
   assign zero_div    = 1'b0;
   assign div_by_zero = 1'b0;
`endif

   assign accept    = start && (state != RUN);
   assign busy      = (state == RUN);
   assign alu_own   = busy;
   assign done      = (state == DONE);
   assign result_hi = p;
   assign result_lo = q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (accept)
               state_nxt = zero_div ? DONE : RUN;
            else
               state_nxt = IDLE;
         end
         RUN: begin
            if (cnt == 3'd7)
               state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The ALU is idle-driven with zeros whenever the sequencer does not own it.
   always_comb begin
      alu_a    = 8'd0;
      alu_b    = 8'd0;
      alu_mode = MODE_PASS;
      alu_cin  = 1'b0;
      if (state == RUN) begin
         alu_b = b;
`ifdef ALU_SEQ_DIV_EN
         if (op_div) begin
            alu_a    = {p[6:0], q[7]};
            alu_mode = MODE_SUB;
         end else begin
            alu_a    = p;
            alu_mode = q[0] ? MODE_ADD : MODE_PASS;
         end
`else
         alu_a    = p;
         alu_mode = q[0] ? MODE_ADD : MODE_PASS;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         p     <= 8'd0;
         q     <= 8'd0;
         b     <= 8'd0;
         cnt   <= 3'd0;
`ifdef ALU_SEQ_DIV_EN
         op_div <= 1'b0;
         dz     <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            b   <= opb;
            cnt <= 3'd0;
`ifdef ALU_SEQ_DIV_EN
            op_div <= op;
            dz     <= zero_div;
`endif
            // Divide by zero skips the iterations and reports an all-ones quotient.
            if (zero_div) begin
               p <= opa;
               q <= 8'hFF;
            end else begin
               p <= 8'd0;
               q <= opa;
            end
         end else if (state == RUN) begin
            cnt <= cnt + 3'd1;
`ifdef ALU_SEQ_DIV_EN
            if (op_div) begin
               p <= div_ok ? alu_out : alu_a;
               q <= {q[6:0], div_ok};
            end else begin
               p <= {alu_cout, alu_out[7:1]};
               q <= {alu_out[0], q[7:1]};
            end
`else
            p <= {alu_cout, alu_out[7:1]};
            q <= {alu_out[0], q[7:1]};
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq with an arithmetic reference model and a behavioural ALU.
// Honours ALU_SEQ_DIV_EN the same way as the design.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst, start, op;
   logic [7:0] opa, opb;
   logic [7:0] alu_a, alu_b, alu_out;
   logic [3:0] alu_mode;
   logic       alu_cin, alu_cout, alu_own, busy, done;
   logic [7:0] result_hi, result_lo;
   logic       div_by_zero;

   int checks   = 0;
   int failures = 0;

`ifdef ALU_SEQ_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   alu_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .opa         (opa),
      .opb         (opb),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_mode    (alu_mode),
      .alu_cin     (alu_cin),
      .alu_out     (alu_out),
      .alu_cout    (alu_cout),
      .alu_own     (alu_own),
      .busy        (busy),
      .done        (done),
      .result_hi   (result_hi),
      .result_lo   (result_lo),
      .div_by_zero (div_by_zero)
   );

   // Purely combinational ALU: pass A, add with carry out, subtract with borrow out.
   logic [8:0] alu_full;
   always_comb begin
      alu_full = 9'd0;
      case (alu_mode)
         4'b0000: alu_full = {1'b0, alu_a};
         4'b0101: alu_full = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
         4'b1000: alu_full = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
         default: alu_full = 9'd0;
      endcase
   end
   assign alu_out  = alu_full[7:0];
   assign alu_cout = alu_full[8];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // {div_by_zero, hi, lo} from plain arithmetic.
   function automatic logic [16:0] expResult(input bit dv, input logic [7:0] a, input logic [7:0] bb);
      int ia, ib;
      ia = int'(a);
      ib = int'(bb);
      if (dv) begin
         if (ib == 0) return {1'b1, a, 8'hFF};
         return {1'b0, 8'(ia % ib), 8'(ia / ib)};
      end
      return {1'b0, 16'(ia * ib)};
   endfunction

   // ALU operand A at iteration i: partial product (MUL) or shifted partial remainder (DIV).
   function automatic logic [7:0] expAluA(input bit dv, input logic [7:0] a, input logic [7:0] bb, input int i);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(bb);
      if (!dv) return 8'(((ia & ((1 << i) - 1)) * ib) >> i);
      r = (ia >> (8 - i)) % ib;
      return 8'((r << 1) | int'(a[7 - i]));
   endfunction

   // Transaction-level model: countdown of remaining iterations plus final results.
   int         m_remaining;
   bit         m_done, m_dz, m_div, can_accept;
   logic [7:0] m_hi, m_lo, m_a, m_b;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_remaining = 0;
         m_done = 1'b0;
         m_dz   = 1'b0;
         m_div  = 1'b0;
         m_hi   = 8'd0;
         m_lo   = 8'd0;
         m_a    = 8'd0;
         m_b    = 8'd0;
      end else begin
         can_accept = (m_remaining == 0);
         m_done = 1'b0;
         if (m_remaining > 0) begin
            m_remaining--;
            if (m_remaining == 0) m_done = 1'b1;
         end
         if (can_accept && start) begin
            m_div = DIV_EN && op;
            m_a   = opa;
            m_b   = opb;
            {m_dz, m_hi, m_lo} = expResult(m_div, opa, opb);
            if (m_dz) m_done = 1'b1;
            else      m_remaining = 8;
         end
      end
   end

   logic [3:0] modeLog[$];

   always @(negedge clk) begin : compare
      int i;
      checkOutput("busy", busy, m_remaining > 0);
      checkOutput("alu_own", alu_own, m_remaining > 0);
      checkOutput("done", done, m_done);
      checkOutput("div_by_zero", div_by_zero, m_dz);
      if (m_remaining == 0) begin
         checkOutput("result_hi", result_hi, m_hi);
         checkOutput("result_lo", result_lo, m_lo);
         checkOutput("idle_alu_a", alu_a, 8'd0);
         checkOutput("idle_alu_b", alu_b, 8'd0);
         checkOutput("idle_alu_mode", alu_mode, 4'd0);
         checkOutput("idle_alu_cin", alu_cin, 1'b0);
      end else begin
         i = 8 - m_remaining;
         modeLog.push_back(alu_mode);
         checkOutput("run_alu_a", alu_a, expAluA(m_div, m_a, m_b, i));
         checkOutput("run_alu_b", alu_b, m_b);
         checkOutput("run_alu_mode", alu_mode, m_div ? 4'b1000 : (m_a[i] ? 4'b0101 : 4'b0000));
         checkOutput("run_alu_cin", alu_cin, 1'b0);
      end
   end

   task automatic applyStimulus(input bit o, input logic [7:0] a, input logic [7:0] bb);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      opa   = a;
      opb   = bb;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts clock edges after the accept edge until done is visible.
   task automatic waitDone(output int edges);
      edges = 0;
      while (done !== 1'b1 && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      if (done !== 1'b1) checkOutput("done_timeout", done, 1'b1);
   endtask

   initial begin
      int edges;
      rst = 1'b1; start = 1'b0; op = 1'b0; opa = 8'd0; opb = 8'd0;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_done", done, 1'b0);
      checkOutput("reset_result", {result_hi, result_lo}, 16'h0000);
      rst = 1'b0;

      // 11 x 13: multiplier bits LSB-first 1,1,0,1,0,0,0,0
      modeLog.delete();
      applyStimulus(1'b0, 8'd11, 8'd13);
      waitDone(edges);
      checkOutput("mul_latency", edges, 8);
      checkOutput("mul_11x13", {result_hi, result_lo}, 16'h008F);
      checkOutput("mode_count", modeLog.size(), 8);
      if (modeLog.size() == 8) begin
         logic [3:0] expModes [8];
         expModes = '{4'h5, 4'h5, 4'h0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0};
         for (int k = 0; k < 8; k++) checkOutput("mode_seq", modeLog[k], expModes[k]);
      end

      // back-to-back with start in the DONE cycle
      applyStimulus(1'b0, 8'hFF, 8'hFF);
      waitDone(edges);
      checkOutput("mul_ffxff", {result_hi, result_lo}, 16'hFE01);
      start = 1'b1; op = 1'b0; opa = 8'h00; opb = 8'h37;
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b_no_idle", busy, 1'b1);
      waitDone(edges);
      checkOutput("b2b_latency", edges, 8);
      checkOutput("mul_0x37", {result_hi, result_lo}, 16'h0000);

      // start during RUN is ignored
      applyStimulus(1'b0, 8'hC3, 8'h5A);
      repeat (3) @(negedge clk);
      start = 1'b1; opa = 8'h01; opb = 8'h01;
      @(negedge clk);
      start = 1'b0;
      waitDone(edges);
      checkOutput("ignored_start", {result_hi, result_lo}, 16'h448E);
      @(negedge clk);
      checkOutput("no_queue", busy, 1'b0);

`ifdef ALU_SEQ_DIV_EN
      applyStimulus(1'b1, 8'd200, 8'd7);
      waitDone(edges);
      checkOutput("div_200_7", {result_hi, result_lo}, 16'h041C);
      applyStimulus(1'b1, 8'hFF, 8'h81);
      waitDone(edges);
      checkOutput("div_ff_81", {result_hi, result_lo}, 16'h7E01);
      applyStimulus(1'b1, 8'h5A, 8'h00);
      waitDone(edges);
      checkOutput("dz_latency", edges, 0);
      checkOutput("dz_result", {result_hi, result_lo}, 16'h5AFF);
      checkOutput("dz_flag", div_by_zero, 1'b1);
      applyStimulus(1'b0, 8'd3, 8'd4);
      checkOutput("dz_cleared", div_by_zero, 1'b0);
      waitDone(edges);
      checkOutput("mul_3x4", {result_hi, result_lo}, 16'h000C);
`else
      applyStimulus(1'b1, 8'd6, 8'd7);
      waitDone(edges);
      checkOutput("op_ignored_6x7", {result_hi, result_lo}, 16'h002A);
      checkOutput("dz_tied", div_by_zero, 1'b0);
`endif

      // reset after E5 aborts the sequence
      applyStimulus(1'b0, 8'h77, 8'h99);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_busy", busy, 1'b0);
      checkOutput("abort_own", alu_own, 1'b0);
      checkOutput("abort_done", done, 1'b0);
      checkOutput("abort_result", {result_hi, result_lo}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) begin
         @(negedge clk);
         checkOutput("no_done_after_abort", done, 1'b0);
      end

      // random traffic, including starts while busy and zero divisors
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         op    = 1'($urandom);
         opa   = 8'($urandom);
         opb   = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL global_timeout: got running, expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] timeout");
   end

endmodule
